// File: rtl/lsu_ctrl_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings and the latched request payload.
package lsu_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 3;

    localparam logic [2:0] LSU_LB  = 3'd0;
    localparam logic [2:0] LSU_LH  = 3'd1;
    localparam logic [2:0] LSU_LW  = 3'd2;
    localparam logic [2:0] LSU_LBU = 3'd4;
    localparam logic [2:0] LSU_LHU = 3'd5;

    localparam logic [2:0] LSU_SB  = 3'd0;
    localparam logic [2:0] LSU_SH  = 3'd1;
    localparam logic [2:0] LSU_SW  = 3'd2;

    // Request fields still needed after the RAM strobe has been issued.
    typedef struct packed {
        logic       store;
        logic [2:0] op;
        logic [1:0] lane;
    } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables/data, load lane select and extension,
// invalid-op and (with LSU_MISALIGN_TRAP_EN defined) misalignment rejection.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic            store,
    input  logic [2:0]      op,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      ld_op,
    input  logic [1:0]      ld_lane,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be_c,
    output logic [XLEN-1:0] wdata_c,
    output logic            err_c,
    output logic [XLEN-1:0] rdata_c
);

    logic       bad_op;
    logic       misalign;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Request rejection.
    always_comb begin
        bad_op   = 1'b0;
        misalign = 1'b0;
        if (store) begin
            bad_op = (op > LSU_SW);
        end else begin
            bad_op = !((op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
                       (op == LSU_LBU) || (op == LSU_LHU));
        end
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((op[1:0] == 2'b01) && lane[0]) ||
                   ((op[1:0] == 2'b10) && (lane != 2'b00));
`endif
        err_c = bad_op | misalign;
    end

    // Store lanes; op[1:0] also classifies the load width for the byte enables.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata;
        case (op[1:0])
            2'b00: begin
                be_c    = 4'(4'b0001 << lane);
                wdata_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = wdata;
            end
        endcase
    end

    // Load lane select and extension.
    always_comb begin
        byte_sel = rdata[7:0];
        case (ld_lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = ld_lane[1] ? rdata[31:16] : rdata[15:0];
        case (ld_op)
            LSU_LB:  rdata_c = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: rdata_c = {24'd0, byte_sel};
            LSU_LH:  rdata_c = {{16{half_sel[15]}}, half_sel};
            LSU_LHU: rdata_c = {16'd0, half_sel};
            LSU_LW:  rdata_c = rdata;
            default: rdata_c = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: one request at a time, word RAM with MEM_LAT read latency.
// Build option: LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_op,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [3:0]        mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state;
    lsu_req_t        req_q;
    logic [CNT_W-1:0] cnt;

    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic            err_c;
    logic [XLEN-1:0] rdata_c;

    // Byte address bits above the RAM word address are don't-care.
    logic unused_addr;
    assign unused_addr = ^req_addr[XLEN-1:ADDR_W+2];

    lsu_align u_align (
        .store   (req_store),
        .op      (req_op),
        .lane    (req_addr[1:0]),
        .wdata   (req_wdata),
        .ld_op   (req_q.op),
        .ld_lane (req_q.lane),
        .rdata   (mem_rdata),
        .be_c    (be_c),
        .wdata_c (wdata_c),
        .err_c   (err_c),
        .rdata_c (rdata_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_q     <= '0;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_addr  <= '0;
            mem_rden  <= 1'b0;
            mem_wren  <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            mem_rden  <= 1'b0;
            mem_wren  <= 1'b0;
            case (state)
                // RESP behaves as IDLE so a new request can follow back-to-back.
                IDLE, RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_q.store <= req_store;
                        req_q.op    <= req_op;
                        req_q.lane  <= req_addr[1:0];
                        if (err_c) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state     <= ACCESS;
                            req_ready <= 1'b0;
                            mem_addr  <= req_addr[ADDR_W+1:2];
                            mem_be    <= be_c;
                            mem_wdata <= wdata_c;
                            mem_rden  <= !req_store;
                            mem_wren  <= req_store;
                        end
                    end
                end
                ACCESS: begin
                    if (req_q.store) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                    end else begin
                        state <= WAIT;
                        cnt   <= CNT_W'(MEM_LAT);
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= rdata_c;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
